// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives the imem word address, queues {pc, inst}
// pairs in a small circular prefetch buffer and hands them to decode via valid/ready.
module fetch_controller #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_inst,
    input  logic                  halt,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_buf_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_buf_d [DEPTH];
    logic [DATA_WIDTH-1:0] inst_buf_q [DEPTH];
    logic [DATA_WIDTH-1:0] inst_buf_d [DEPTH];

    logic pop;
    logic push;

    always_comb begin
        pop  = (count_q != '0) && out_ready;
        // A pop frees a slot in the same edge, so a full buffer can still accept a fetch.
        push = !redirect_valid && !halt && ((count_q != FULL) || pop);

        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pc_buf_d   = pc_buf_q;
        inst_buf_d = inst_buf_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                pc_buf_d[wr_ptr_q]   = fetch_pc_q;
                inst_buf_d[wr_ptr_q] = imem_inst;
                wr_ptr_d             = wr_ptr_q + 1'b1;
                fetch_pc_d           = fetch_pc_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pc_buf_q   <= '{default: '0};
            inst_buf_q <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pc_buf_q   <= pc_buf_d;
            inst_buf_q <= inst_buf_d;
        end
    end

    // Stale slots keep old data after a pop, so gate the head with out_valid.
    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? pc_buf_q[rd_ptr_q]   : '0;
    assign out_inst  = out_valid ? inst_buf_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: expected deliveries are queued by the
// stimulus and popped by a monitor on every accepted handshake.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_inst;
    logic        halt;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [31:0] out_inst;

    int tests  = 0;
    int failed = 0;
    logic [39:0] exp_q[$];

    always #5 clk = ~clk;

    // Memory word i holds 32'h1000_0000 + i.
    assign imem_inst = 32'h1000_0000 + {24'h0, imem_addr};

    fetch_controller #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .RESET_PC  (8'h00),
        .DEPTH     (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_inst     (imem_inst),
        .halt          (halt),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst)
    );

    // Monitor: every accepted handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            logic [39:0] e;
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL deliver_unexpected: got pc=%h inst=%h, required no delivery",
                         out_pc, out_inst);
            end else begin
                e = exp_q.pop_front();
                if ({out_pc, out_inst} !== e) begin
                    failed++;
                    $display("FAIL deliver: got pc=%h inst=%h, required pc=%h inst=%h",
                             out_pc, out_inst, e[39:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the scoreboard to empty; also checks how many cycles it took.
    task automatic drain(input string name, input int exp_cycles);
        int cycles = 0;
        while (exp_q.size() != 0 && cycles < 20) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL %s_timeout: %0d entries undelivered, required 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            check({name, "_cycles"}, 40'(cycles), 40'(exp_cycles));
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        out_ready      = 1'b1;

        // Reset state, then streaming at full rate.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 40'(out_valid), 40'd0);
        check("rst_out_pc",    40'(out_pc),    40'd0);
        check("rst_out_inst",  40'(out_inst),  40'd0);
        check("rst_imem_addr", 40'(imem_addr), 40'd0);
        push_exp(8'h00, 32'h1000_0000);
        push_exp(8'h01, 32'h1000_0001);
        push_exp(8'h02, 32'h1000_0002);
        push_exp(8'h03, 32'h1000_0003);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("first_latency_valid", 40'(out_valid), 40'd0);
        drain("stream", 4);
        tick();
        out_ready = 1'b0;

        // Backpressure from pc 0.
        reset_dut();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("bp_valid", 40'(out_valid), 40'd1);
                check("bp_pc",    40'(out_pc),    40'h00);
                check("bp_inst",  40'(out_inst),  40'h1000_0000);
            end
        end
        check("bp_imem_addr", 40'(imem_addr), 40'h02);
        tick();
        push_exp(8'h00, 32'h1000_0000);
        push_exp(8'h01, 32'h1000_0001);
        push_exp(8'h02, 32'h1000_0002);
        push_exp(8'h03, 32'h1000_0003);
        out_ready = 1'b1;
        drain("bp_release", 4);
        tick();
        out_ready = 1'b0;

        // Redirect while pc 1 is at the head and being accepted.
        reset_dut();
        out_ready = 1'b1;
        push_exp(8'h00, 32'h1000_0000);
        push_exp(8'h01, 32'h1000_0001);
        push_exp(8'h40, 32'h1000_0040);
        push_exp(8'h41, 32'h1000_0041);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_flush_valid", 40'(out_valid), 40'd0);
        check("redir_imem_addr",   40'(imem_addr), 40'h40);
        drain("redir", 2);
        tick();
        out_ready = 1'b0;

        // Redirect near the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        push_exp(8'hFE, 32'h1000_00FE);
        push_exp(8'hFF, 32'h1000_00FF);
        push_exp(8'h00, 32'h1000_0000);
        push_exp(8'h01, 32'h1000_0001);
        tick();
        redirect_valid = 1'b0;
        check("wrap_imem_addr", 40'(imem_addr), 40'hFE);
        check("wrap_valid",     40'(out_valid), 40'd0);
        out_ready = 1'b1;
        drain("wrap", 5);
        tick();
        out_ready = 1'b0;

        // Halt with two entries buffered: drain then freeze.
        tick();
        tick();
        check("halt_pre_valid", 40'(out_valid), 40'd1);
        check("halt_pre_pc",    40'(out_pc),    40'h02);
        check("halt_pre_addr",  40'(imem_addr), 40'h04);
        halt      = 1'b1;
        out_ready = 1'b1;
        push_exp(8'h02, 32'h1000_0002);
        push_exp(8'h03, 32'h1000_0003);
        drain("halt_drain", 2);
        @(negedge clk);
        check("halt_empty_valid", 40'(out_valid), 40'd0);
        check("halt_empty_pc",    40'(out_pc),    40'd0);
        check("halt_empty_inst",  40'(out_inst),  40'd0);
        check("halt_addr",        40'(imem_addr), 40'h04);
        repeat (3) @(negedge clk);
        check("halt_addr_frozen", 40'(imem_addr), 40'h04);
        check("halt_still_empty", 40'(out_valid), 40'd0);
        tick();
        halt = 1'b0;
        push_exp(8'h04, 32'h1000_0004);
        push_exp(8'h05, 32'h1000_0005);
        push_exp(8'h06, 32'h1000_0006);
        drain("halt_resume", 4);
        tick();

        // Asynchronous reset in the middle of a cycle.
        push_exp(8'h07, 32'h1000_0007);
        push_exp(8'h08, 32'h1000_0008);
        drain("pre_areset", 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 40'(out_valid), 40'd0);
        check("areset_addr",  40'(imem_addr), 40'h00);
        check("areset_pc",    40'(out_pc),    40'd0);
        check("areset_inst",  40'(out_inst),  40'd0);
        tick();
        tick();
        rst_n = 1'b1;
        push_exp(8'h00, 32'h1000_0000);
        push_exp(8'h01, 32'h1000_0001);
        push_exp(8'h02, 32'h1000_0002);
        drain("areset_restart", 4);
        tick();
        out_ready = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
